// File: rtl/uart_pkg.sv
// Shared types and constants for the UART report scheduler.
// Configuration macro used by the top: UART_REPORT_SCHED_TIMEOUT_EN.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ENC  = 2'd1,
      SEND = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      K_FAIL = 2'd0,
      K_OK   = 2'd1,
      K_RD   = 2'd2
   } kind_t;

   // Number of leading ENC_MSG bytes that belong to each report kind
   localparam int unsigned LEN_RD   = 10;
   localparam int unsigned LEN_OK   = 4;
   localparam int unsigned LEN_FAIL = 6;

   // Every report ends with a line feed followed by the prompt character
   localparam logic [7:0] LF     = 8'h0A;
   localparam logic [7:0] PROMPT = 8'h3E;

   function automatic logic [3:0] kind_len(input kind_t k);
      case (k)
         K_RD:    return 4'(LEN_RD);
         K_OK:    return 4'(LEN_OK);
         default: return 4'(LEN_FAIL);
      endcase
   endfunction

endpackage

// File: rtl/uart_prio_arb.sv
// Fixed-priority 3-way arbiter: bit0 > bit1 > bit2, one-hot grant,
// forced to zero while i_en is low.
module uart_prio_arb (
   input  logic       i_en,
   input  logic [2:0] i_req,
   output logic [2:0] o_gnt
);

   // Lowest-index pending request wins while enabled
   always_comb begin
      o_gnt = '0;
      if (i_en) begin
         if (i_req[0])      o_gnt = 3'b001;
         else if (i_req[1]) o_gnt = 3'b010;
         else if (i_req[2]) o_gnt = 3'b100;
      end
   end

endmodule

// File: rtl/uart_report_sched.sv
// Report request sequencer: arbitrates FAIL/OK/RD requests, drives the ASCII
// encoder for ENC_LAT cycles, captures its message and streams the valid bytes
// MSB-first over a valid/ready byte interface.
// Optional build macro UART_REPORT_SCHED_TIMEOUT_EN adds a TX stall timeout
// that aborts the current message after TIMEOUT_CYC stalled cycles.
module uart_report_sched
   import uart_pkg::*;
#(
   parameter int unsigned ENC_LAT     = 2,
   parameter int unsigned TIMEOUT_CYC = 65535
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [2:0]  REQ,
   input  logic [31:0] RD_DATA,
   output logic [2:0]  GNT,
   output logic        BUSY,
   output logic        ENC_EN,
   output logic [31:0] ENC_DATA,
   output logic        ENC_STATE_R,
   output logic        ENC_OK,
   output logic        ENC_FAIL,
   input  logic [79:0] ENC_MSG,
   output logic [7:0]  TX_DATA,
   output logic        TX_VALID,
   input  logic        TX_READY,
   output logic        ABORT
);

   if (ENC_LAT < 1 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_cfg_err
      $error("uart_report_sched: need ENC_LAT >= 1 and 1 <= TIMEOUT_CYC <= 65535");
   end

   localparam int unsigned     LW       = (ENC_LAT > 1) ? $clog2(ENC_LAT) : 1;
   localparam logic [LW-1:0]   LAT_LAST = LW'(ENC_LAT - 1);

   state_t        r_state;
   kind_t         r_kind;
   logic          r_busy;
   logic          r_enc_en;
   logic [31:0]   r_enc_data;
   logic          r_enc_rd;
   logic          r_enc_ok;
   logic          r_enc_fail;
   logic          r_tx_valid;
   logic [79:0]   r_shift;
   logic [3:0]    r_cnt;
   logic [LW-1:0] r_lat;
`ifdef UART_REPORT_SCHED_TIMEOUT_EN
   localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYC - 1);
   logic [15:0]   r_stall;
   logic          r_abort;
`endif

   logic [2:0]    w_gnt;
   logic          w_accept;

   // Grants are only issued from IDLE and never while reset is asserted
   uart_prio_arb u_arb (
      .i_en  (r_state == IDLE && RST_N),
      .i_req (REQ),
      .o_gnt (w_gnt)
   );

   assign w_accept = r_tx_valid & TX_READY;

   // Scheduler FSM: grant -> encoder hold -> byte streaming
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state    <= IDLE;
         r_kind     <= K_FAIL;
         r_busy     <= 1'b0;
         r_enc_en   <= 1'b0;
         r_enc_data <= '0;
         r_enc_rd   <= 1'b0;
         r_enc_ok   <= 1'b0;
         r_enc_fail <= 1'b0;
         r_tx_valid <= 1'b0;
         r_shift    <= '0;
         r_cnt      <= '0;
         r_lat      <= '0;
`ifdef UART_REPORT_SCHED_TIMEOUT_EN
         r_stall    <= '0;
         r_abort    <= 1'b0;
`endif
      end else begin
`ifdef UART_REPORT_SCHED_TIMEOUT_EN
         r_abort <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (|w_gnt) begin
                  r_state  <= ENC;
                  r_busy   <= 1'b1;
                  r_enc_en <= 1'b1;
                  r_lat    <= '0;
                  if (w_gnt[0]) begin
                     r_kind     <= K_FAIL;
                     r_enc_fail <= 1'b1;
                     r_enc_data <= '0;
                  end else if (w_gnt[1]) begin
                     r_kind     <= K_OK;
                     r_enc_ok   <= 1'b1;
                     r_enc_data <= '0;
                  end else begin
                     r_kind     <= K_RD;
                     r_enc_rd   <= 1'b1;
                     r_enc_data <= RD_DATA;
                  end
               end
            end
            ENC: begin
               if (r_lat == LAT_LAST) begin
                  r_shift    <= ENC_MSG;
                  r_cnt      <= kind_len(r_kind);
                  r_enc_en   <= 1'b0;
                  r_enc_data <= '0;
                  r_enc_rd   <= 1'b0;
                  r_enc_ok   <= 1'b0;
                  r_enc_fail <= 1'b0;
                  r_tx_valid <= 1'b1;
                  r_state    <= SEND;
`ifdef UART_REPORT_SCHED_TIMEOUT_EN
                  r_stall    <= '0;
`endif
               end else begin
                  r_lat <= r_lat + 1'b1;
               end
            end
            SEND: begin
               if (w_accept) begin
`ifdef UART_REPORT_SCHED_TIMEOUT_EN
                  r_stall <= '0;
`endif
                  if (r_cnt == 4'd1) begin
                     // Clearing the shifter keeps unsent trailing bytes off TX_DATA
                     r_tx_valid <= 1'b0;
                     r_busy     <= 1'b0;
                     r_shift    <= '0;
                     r_cnt      <= '0;
                     r_state    <= IDLE;
                  end else begin
                     r_shift <= {r_shift[71:0], 8'h00};
                     r_cnt   <= r_cnt - 1'b1;
                  end
               end
`ifdef UART_REPORT_SCHED_TIMEOUT_EN
               else if (r_stall == STALL_LAST) begin
                  r_abort    <= 1'b1;
                  r_tx_valid <= 1'b0;
                  r_busy     <= 1'b0;
                  r_shift    <= '0;
                  r_cnt      <= '0;
                  r_stall    <= '0;
                  r_state    <= IDLE;
               end else begin
                  r_stall <= r_stall + 1'b1;
               end
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign GNT         = w_gnt;
   assign BUSY        = r_busy | (|w_gnt);
   assign ENC_EN      = r_enc_en;
   assign ENC_DATA    = r_enc_data;
   assign ENC_STATE_R = r_enc_rd;
   assign ENC_OK      = r_enc_ok;
   assign ENC_FAIL    = r_enc_fail;
   assign TX_DATA     = r_shift[79:72];
   assign TX_VALID    = r_tx_valid;
`ifdef UART_REPORT_SCHED_TIMEOUT_EN
   assign ABORT       = r_abort;
`else
   assign ABORT       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_report_sched.sv
// Directed bench for uart_report_sched with a behavioural ASCII encoder.
// Honours UART_REPORT_SCHED_TIMEOUT_EN for the stall/abort scenario.
module tb_uart_report_sched;

   localparam int unsigned ENC_LAT = 2;

   typedef logic [7:0] bq_t[$];

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [2:0]  REQ;
   logic [31:0] RD_DATA;
   logic [2:0]  GNT;
   logic        BUSY;
   logic        ENC_EN;
   logic [31:0] ENC_DATA;
   logic        ENC_STATE_R;
   logic        ENC_OK;
   logic        ENC_FAIL;
   logic [79:0] ENC_MSG;
   logic [7:0]  TX_DATA;
   logic        TX_VALID;
   logic        TX_READY;
   logic        ABORT;

   int n_chk = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   uart_report_sched #(
      .ENC_LAT     (ENC_LAT),
      .TIMEOUT_CYC (8)
   ) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .REQ         (REQ),
      .RD_DATA     (RD_DATA),
      .GNT         (GNT),
      .BUSY        (BUSY),
      .ENC_EN      (ENC_EN),
      .ENC_DATA    (ENC_DATA),
      .ENC_STATE_R (ENC_STATE_R),
      .ENC_OK      (ENC_OK),
      .ENC_FAIL    (ENC_FAIL),
      .ENC_MSG     (ENC_MSG),
      .TX_DATA     (TX_DATA),
      .TX_VALID    (TX_VALID),
      .TX_READY    (TX_READY),
      .ABORT       (ABORT)
   );

   logic [49:0] w_outs;
   assign w_outs = {GNT, BUSY, ENC_EN, ENC_DATA, ENC_STATE_R, ENC_OK, ENC_FAIL,
                    TX_DATA, TX_VALID, ABORT};

   // Encoder model: message is only valid in the ENC_LAT-th enabled cycle,
   // garbage otherwise, with filler bytes after the real message.
   int unsigned en_cnt;
   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N)      en_cnt <= 0;
      else if (ENC_EN) en_cnt <= en_cnt + 1;
      else             en_cnt <= 0;
   end

   function automatic logic [7:0] hexc(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   always_comb begin
      ENC_MSG = {10{8'hA5}};
      if (ENC_EN && en_cnt == ENC_LAT - 1) begin
         if (ENC_FAIL)    ENC_MSG = {48'h4641494C0A3E, 32'hCCCCCCCC};
         else if (ENC_OK) ENC_MSG = {32'h4F4B0A3E, 48'hCCCCCCCCCCCC};
         else if (ENC_STATE_R) begin
            for (int i = 0; i < 8; i++) ENC_MSG[79-8*i -: 8] = hexc(ENC_DATA[31-4*i -: 4]);
            ENC_MSG[15:0] = 16'h0A3E;
         end
      end
   end

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_gnt(input string tag, input logic [2:0] exp);
      int t = 0;
      do begin
         @(negedge CLK);
         t++;
      end while (GNT == 3'b000 && t < 30);
      check({tag, ".gnt"}, 80'(GNT), 80'(exp));
      check({tag, ".gnt_no_tx"}, 80'(TX_VALID), 80'(0));
      check({tag, ".busy"}, 80'(BUSY), 80'(1));
   endtask

   // Collects accepted bytes; returns at #1 after the edge of the last accept
   task automatic collect(input string tag, input bq_t exp, output int first_t, output int last_t);
      bq_t got;
      int  t = 0;
      first_t = -1;
      last_t  = -1;
      while (got.size() < exp.size() && t < 400) begin
         @(negedge CLK);
         t++;
         if (TX_VALID && TX_READY) begin
            got.push_back(TX_DATA);
            if (first_t < 0) first_t = t;
            last_t = t;
         end
      end
      if (got.size() == exp.size()) begin
         @(posedge CLK);
         #1;
      end
      check({tag, ".count"}, 80'(got.size()), 80'(exp.size()));
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         check($sformatf("%s.byte%0d", tag, i), 80'(got[i]), 80'(exp[i]));
      check({tag, ".gap_no_valid"}, 80'(TX_VALID), 80'(0));
   endtask

   initial begin
      #400000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t e_fail, e_ok, e_rd0, e_dead, e_tail;
      bq_t got;
      int  f, l, n, t, st;

      e_fail = '{8'h46, 8'h41, 8'h49, 8'h4C, 8'h0A, 8'h3E};
      e_ok   = '{8'h4F, 8'h4B, 8'h0A, 8'h3E};
      e_rd0  = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0A, 8'h3E};
      e_dead = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0A, 8'h3E};
      e_tail = '{8'h4B, 8'h0A, 8'h3E};

      RST_N = 1'b0; REQ = '0; RD_DATA = '0; TX_READY = 1'b1;
      #1 check("reset.outs", 80'(w_outs), 80'(0));
      repeat (2) @(posedge CLK);
      #1 RST_N = 1'b1;
      @(negedge CLK) check("reset.idle", 80'(w_outs), 80'(0));

      // 1: FAIL message, back-to-back bytes
      REQ = 3'b001;
      wait_gnt("t1", 3'b001);
      @(posedge CLK); #1 REQ = '0;
      @(negedge CLK) check("t1.gnt_pulse", 80'(GNT), 80'(0));
      collect("t1", e_fail, f, l);
      check("t1.consecutive", 80'(l - f), 80'(5));
      check("t1.busy_fall", 80'(BUSY), 80'(0));

      // 2: RD report, data latched at grant
      RD_DATA = 32'hDEADBEEF; REQ = 3'b100;
      wait_gnt("t2", 3'b100);
      @(posedge CLK); #1 REQ = '0; RD_DATA = '0;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         check($sformatf("t2.enc_lines%0d", i), 80'({ENC_EN, ENC_STATE_R, ENC_OK, ENC_FAIL}), 80'(4'b1100));
         check($sformatf("t2.enc_data%0d", i), 80'(ENC_DATA), 80'(32'hDEADBEEF));
      end
      @(posedge CLK); #1;
      check("t2.enc_exit", 80'({ENC_EN, ENC_STATE_R, ENC_DATA, TX_VALID}), 80'({2'b00, 32'h0, 1'b1}));
      collect("t2", e_dead, f, l);

      // 3: all three pending, priority order with idle gap
      RD_DATA = '0; REQ = 3'b111;
      wait_gnt("t3a", 3'b001);
      @(posedge CLK); #1 REQ = 3'b110;
      collect("t3a", e_fail, f, l);
      wait_gnt("t3b", 3'b010);
      @(posedge CLK); #1 REQ = 3'b100;
      collect("t3b", e_ok, f, l);
      wait_gnt("t3c", 3'b100);
      @(posedge CLK); #1 REQ = '0;
      collect("t3c", e_rd0, f, l);

      // 4: backpressure on the second byte
      REQ = 3'b010;
      wait_gnt("t4", 3'b010);
      @(posedge CLK); #1 REQ = '0;
      t = 0;
      do begin
         @(negedge CLK);
         t++;
      end while (!TX_VALID && t < 10);
      check("t4.byte0", 80'(TX_DATA), 80'(8'h4F));
      @(posedge CLK); #1 TX_READY = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         check($sformatf("t4.hold%0d", i), 80'({TX_VALID, TX_DATA}), 80'({1'b1, 8'h4B}));
      end
      @(posedge CLK); #1 TX_READY = 1'b1;
      collect("t4", e_tail, f, l);

      // 5: reset in the middle of an RD message
      RD_DATA = 32'h12345678; REQ = 3'b100;
      wait_gnt("t5", 3'b100);
      @(posedge CLK); #1 REQ = '0;
      got = {};
      t = 0;
      while (got.size() < 3 && t < 50) begin
         @(negedge CLK);
         t++;
         if (TX_VALID && TX_READY) got.push_back(TX_DATA);
      end
      @(posedge CLK); #1 RST_N = 1'b0; REQ = 3'b010;
      #1 check("t5.reset_outs", 80'(w_outs), 80'(0));
      check("t5.pre_count", 80'(got.size()), 80'(3));
      if (got.size() == 3) begin
         check("t5.pre0", 80'(got[0]), 80'(8'h31));
         check("t5.pre1", 80'(got[1]), 80'(8'h32));
         check("t5.pre2", 80'(got[2]), 80'(8'h33));
      end
      repeat (2) @(posedge CLK);
      #1 check("t5.reset_hold", 80'(w_outs), 80'(0));
      RST_N = 1'b1;
      wait_gnt("t5b", 3'b010);
      @(posedge CLK); #1 REQ = '0;
      collect("t5b", e_ok, f, l);

      // 6: TX stalled from the first byte
      TX_READY = 1'b0; REQ = 3'b001;
      wait_gnt("t6", 3'b001);
      @(posedge CLK); #1 REQ = '0;
`ifdef UART_REPORT_SCHED_TIMEOUT_EN
      st = 0;
      t  = 0;
      while (t < 40) begin
         @(negedge CLK);
         t++;
         if (ABORT) break;
         if (TX_VALID) st++;
      end
      check("t6.stall_cycles", 80'(st), 80'(8));
      check("t6.abort_outs", 80'({ABORT, TX_VALID, BUSY}), 80'(3'b100));
      @(negedge CLK) check("t6.abort_pulse", 80'(ABORT), 80'(0));
      @(posedge CLK); #1 TX_READY = 1'b1; REQ = 3'b010;
      wait_gnt("t6b", 3'b010);
      @(posedge CLK); #1 REQ = '0;
      collect("t6b", e_ok, f, l);
`else
      st = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if ({ABORT, TX_VALID, TX_DATA} == {1'b0, 1'b1, 8'h46}) st++;
      end
      check("t6.stall_wait", 80'(st), 80'(18));
      check("t6.busy_held", 80'(BUSY), 80'(1));
      @(posedge CLK); #1 TX_READY = 1'b1;
      collect("t6", e_fail, f, l);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
